// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_pkg
// Description : Shared types for the RISC-V load/store unit.
//               - FSM state and response-cause enums
//               - funct3 access-size encodings
//               - request legality/alignment check
// Revision    : 1.0  initial release
// ============================================================================
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_OK       = 3'd0,
        CAUSE_MISALIGN = 3'd1,
        CAUSE_BUSERR   = 3'd2,
        CAUSE_TIMEOUT  = 3'd3,
        CAUSE_ILLEGAL  = 3'd4
    } cause_e;

    // funct3[1:0] access size
    localparam logic [1:0] c_SIZE_BYTE   = 2'b00;
    localparam logic [1:0] c_SIZE_HALF   = 2'b01;
    localparam logic [1:0] c_SIZE_WORD   = 2'b10;
    localparam logic [1:0] c_SIZE_DOUBLE = 2'b11;

    // Classify a request. An illegal encoding outranks a misaligned address.
    function automatic cause_e check_req(input logic       we,
                                         input logic [2:0] funct,
                                         input logic [2:0] addr_lo,
                                         input logic       xlen64);
        logic illegal;
        logic misalign;
        illegal = (funct == 3'b111) ||
                  (we && funct[2]) ||
                  (!xlen64 && ((funct[1:0] == c_SIZE_DOUBLE) || (funct == 3'b110)));
        case (funct[1:0])
            c_SIZE_BYTE: misalign = 1'b0;
            c_SIZE_HALF: misalign = addr_lo[0];
            c_SIZE_WORD: misalign = |addr_lo[1:0];
            default:     misalign = |addr_lo;
        endcase
        if (illegal) begin
            return CAUSE_ILLEGAL;
        end else if (misalign) begin
            return CAUSE_MISALIGN;
        end
        return CAUSE_OK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_if
// Description : Core request/response and memory bus bundle of the LSU.
//               master : the LSU view (accepts core requests, drives memory)
//               slave  : the environment view (core plus memory)
// Revision    : 1.0  initial release
// ============================================================================
interface riscv_lsu_if #(
    parameter int XLEN = 32
) ();
    // core request
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    // core response
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic [2:0]        rsp_cause;
    // memory bus
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport master (
        input  req_valid, req_we, req_funct, req_addr, req_wdata,
        input  mem_ready, mem_rdata, mem_err,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_cause,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output req_valid, req_we, req_funct, req_addr, req_wdata,
        output mem_ready, mem_rdata, mem_err,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_cause,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface
`default_nettype wire

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for the LSU.
//               wr_* : byte-enable mask and write-lane shift of store data
//               rd_* : read-lane shift and sign/zero extension of load data
// Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [1:0]                wr_size,
    input  wire logic [$clog2(XLEN/8)-1:0] wr_off,
    input  wire logic [XLEN-1:0]           wr_data,
    output logic      [XLEN/8-1:0]         wr_be,
    output logic      [XLEN-1:0]           wr_lanes,
    input  wire logic [1:0]                rd_size,
    input  wire logic                      rd_unsigned,
    input  wire logic [$clog2(XLEN/8)-1:0] rd_off,
    input  wire logic [XLEN-1:0]           rd_data,
    output logic      [XLEN-1:0]           rd_ext
);

    localparam int c_NBYTES = XLEN / 8;

    function automatic logic [XLEN-1:0] data_mask(input logic [1:0] size);
        case (size)
            c_SIZE_BYTE: return XLEN'(8'hFF);
            c_SIZE_HALF: return XLEN'(16'hFFFF);
            c_SIZE_WORD: return XLEN'(32'hFFFF_FFFF);
            default:     return '1;
        endcase
    endfunction

    logic [c_NBYTES-1:0] w_be_mask;
    logic [XLEN-1:0]     w_rd_sh;
    logic [XLEN-1:0]     w_rd_mask;
    logic                w_sign;

    always_comb begin
        case (wr_size)
            c_SIZE_BYTE: w_be_mask = c_NBYTES'(1);
            c_SIZE_HALF: w_be_mask = c_NBYTES'(2'b11);
            c_SIZE_WORD: w_be_mask = c_NBYTES'(4'hF);
            default:     w_be_mask = '1;
        endcase
        wr_be    = w_be_mask << wr_off;
        // Bytes above the access size are dropped so unused lanes stay zero.
        wr_lanes = (wr_data & data_mask(wr_size)) << {wr_off, 3'b000};
    end

    always_comb begin
        w_rd_sh   = rd_data >> {rd_off, 3'b000};
        w_rd_mask = data_mask(rd_size);
        case (rd_size)
            c_SIZE_BYTE: w_sign = w_rd_sh[7];
            c_SIZE_HALF: w_sign = w_rd_sh[15];
            c_SIZE_WORD: w_sign = w_rd_sh[31];
            default:     w_sign = 1'b0;
        endcase
        // Extension by masking avoids zero-width replications at full width.
        rd_ext = (w_rd_sh & w_rd_mask) | ((w_sign && !rd_unsigned) ? ~w_rd_mask : '0);
    end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : RISC-V load/store unit. Accepts one core request at a time,
//               rejects illegal or misaligned accesses directly, otherwise
//               issues one aligned memory transfer with a bus timeout and
//               returns a single-cycle response.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               bus   - riscv_lsu_if.master (core req/rsp + memory bus)
// Revision    : 1.0  initial release
// ============================================================================
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic    clk,
    input  wire logic    reset,
    riscv_lsu_if.master  bus
);

    localparam int              c_NBYTES    = XLEN / 8;
    localparam int              c_OFF_W     = $clog2(c_NBYTES);
    localparam int              c_CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT - 1);
    localparam bit              c_TO_EN     = (TIMEOUT != 0);
    localparam bit              c_XLEN64    = (XLEN == 64);

    state_e               r_state;
    state_e               w_state_nxt;
    cause_e               w_req_cause;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_timeout;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [c_OFF_W-1:0]   r_off;
    logic                 r_we;

    logic                 r_mem_valid;
    logic                 r_mem_we;
    logic [XLEN-1:0]      r_mem_addr;
    logic [XLEN-1:0]      r_mem_wdata;
    logic [c_NBYTES-1:0]  r_mem_be;

    logic                 r_rsp_valid;
    logic [XLEN-1:0]      r_rsp_rdata;
    cause_e               r_rsp_cause;

    logic [c_NBYTES-1:0]  w_wr_be;
    logic [XLEN-1:0]      w_wr_lanes;
    logic [XLEN-1:0]      w_rd_ext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .wr_size     (bus.req_funct[1:0]),
        .wr_off      (bus.req_addr[c_OFF_W-1:0]),
        .wr_data     (bus.req_wdata),
        .wr_be       (w_wr_be),
        .wr_lanes    (w_wr_lanes),
        .rd_size     (r_size),
        .rd_unsigned (r_unsigned),
        .rd_off      (r_off),
        .rd_data     (bus.mem_rdata),
        .rd_ext      (w_rd_ext)
    );

    assign w_req_cause = check_req(bus.req_we, bus.req_funct, bus.req_addr[2:0], c_XLEN64);
    assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
    assign w_done      = (r_state == ST_BUS) && bus.mem_ready;
    // mem_ready in the limit cycle wins because w_timeout requires !mem_ready.
    assign w_timeout   = c_TO_EN && (r_state == ST_BUS) && !bus.mem_ready &&
                         (r_cnt == c_CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_req_cause == CAUSE_OK) ? ST_BUS : ST_RESP;
                end
            end
            ST_BUS: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_off       <= '0;
            r_we        <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_cause <= CAUSE_OK;
        end else begin
            // Response fields are single-cycle and read as zero otherwise.
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_cause <= CAUSE_OK;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_size     <= bus.req_funct[1:0];
                        r_unsigned <= bus.req_funct[2];
                        r_off      <= bus.req_addr[c_OFF_W-1:0];
                        r_we       <= bus.req_we;
                        r_cnt      <= '0;
                        if (w_req_cause == CAUSE_OK) begin
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_addr  <= {bus.req_addr[XLEN-1:c_OFF_W], c_OFF_W'(0)};
                            r_mem_be    <= w_wr_be;
                            r_mem_wdata <= w_wr_lanes;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_cause <= w_req_cause;
                        end
                    end
                end
                ST_BUS: begin
                    if (w_done || w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                        r_rsp_valid <= 1'b1;
                        if (w_timeout) begin
                            r_rsp_cause <= CAUSE_TIMEOUT;
                        end else if (bus.mem_err) begin
                            r_rsp_cause <= CAUSE_BUSERR;
                        end else if (!r_we) begin
                            r_rsp_rdata <= w_rd_ext;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_cause = r_rsp_cause;
    assign bus.rsp_err   = (r_rsp_cause != CAUSE_OK);

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_riscv_lsu
// Description : Scoreboard bench for riscv_lsu. A 32-bit instance (TIMEOUT=4)
//               and a 64-bit instance are driven with directed vectors;
//               monitors pop expected memory requests and responses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_lsu;

    typedef struct {
        logic [63:0] rdata;
        logic [2:0]  cause;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } mem_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rsp_t q_rsp32[$];
    rsp_t q_rsp64[$];
    mem_t q_mem32[$];
    mem_t q_mem64[$];

    always #5 clk = ~clk;

    riscv_lsu_if #(.XLEN(32)) b32();
    riscv_lsu_if #(.XLEN(64)) b64();

    riscv_lsu #(.XLEN(32), .TIMEOUT(4))  u_dut32 (.clk(clk), .reset(reset), .bus(b32.master));
    riscv_lsu #(.XLEN(64), .TIMEOUT(16)) u_dut64 (.clk(clk), .reset(reset), .bus(b64.master));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : p_mon32
        rsp_t r;
        mem_t m;
        if (mon_en) begin
            if (b32.mem_valid && b32.mem_ready) begin
                check("mem32_expected", q_mem32.size() != 0, 1);
                if (q_mem32.size() != 0) begin
                    m = q_mem32.pop_front();
                    check("mem32_we",    b32.mem_we,    m.we);
                    check("mem32_addr",  b32.mem_addr,  m.addr);
                    check("mem32_be",    b32.mem_be,    m.be);
                    check("mem32_wdata", b32.mem_wdata, m.wdata);
                end
            end
            if (b32.rsp_valid) begin
                check("rsp32_expected", q_rsp32.size() != 0, 1);
                if (q_rsp32.size() != 0) begin
                    r = q_rsp32.pop_front();
                    check("rsp32_rdata", b32.rsp_rdata, r.rdata);
                    check("rsp32_cause", b32.rsp_cause, r.cause);
                    check("rsp32_err",   b32.rsp_err,   r.cause != 3'd0);
                end
            end else begin
                check("rsp32_idle_zero", {b32.rsp_rdata, b32.rsp_err, b32.rsp_cause}, 0);
            end
        end
    end

    always @(negedge clk) begin : p_mon64
        rsp_t r;
        mem_t m;
        if (mon_en) begin
            if (b64.mem_valid && b64.mem_ready) begin
                check("mem64_expected", q_mem64.size() != 0, 1);
                if (q_mem64.size() != 0) begin
                    m = q_mem64.pop_front();
                    check("mem64_we",    b64.mem_we,    m.we);
                    check("mem64_addr",  b64.mem_addr,  m.addr);
                    check("mem64_be",    b64.mem_be,    m.be);
                    check("mem64_wdata", b64.mem_wdata, m.wdata);
                end
            end
            if (b64.rsp_valid) begin
                check("rsp64_expected", q_rsp64.size() != 0, 1);
                if (q_rsp64.size() != 0) begin
                    r = q_rsp64.pop_front();
                    check("rsp64_rdata", b64.rsp_rdata, r.rdata);
                    check("rsp64_cause", b64.rsp_cause, r.cause);
                    check("rsp64_err",   b64.rsp_err,   r.cause != 3'd0);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // delay = idle cycles with mem_ready low before the single mem_ready pulse.
    task automatic txn32(input logic we, input logic [2:0] funct, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mrdata, input logic merr,
                         input int delay, input logic exp_mem, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata, input logic [2:0] e_cause);
        rsp_t r;
        mem_t m;
        r.rdata = 64'(e_rdata);
        r.cause = e_cause;
        q_rsp32.push_back(r);
        if (exp_mem) begin
            m.we = we; m.addr = 64'(e_addr); m.be = 8'(e_be); m.wdata = 64'(e_wdata);
            q_mem32.push_back(m);
        end
        @(posedge clk); #1;
        check("req32_ready_idle", b32.req_ready, 1);
        b32.req_valid = 1'b1; b32.req_we = we; b32.req_funct = funct;
        b32.req_addr = addr;  b32.req_wdata = wdata;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        check("mem32_valid_n1", b32.mem_valid, exp_mem);
        if (exp_mem) begin
            repeat (delay) begin @(posedge clk); #1; end
            b32.mem_ready = 1'b1; b32.mem_rdata = mrdata; b32.mem_err = merr;
            @(posedge clk); #1;
            b32.mem_ready = 1'b0; b32.mem_err = 1'b0; b32.mem_rdata = 32'h5A5A_5A5A;
        end
        check("rsp32_valid_slot", b32.rsp_valid, 1);
        @(posedge clk); #1;
        check("req32_ready_after", b32.req_ready, 1);
        check("rsp32_single_pulse", b32.rsp_valid, 0);
    endtask

    task automatic txn64(input logic we, input logic [2:0] funct, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] mrdata,
                         input logic exp_mem, input logic [63:0] e_addr, input logic [7:0] e_be,
                         input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                         input logic [2:0] e_cause);
        rsp_t r;
        mem_t m;
        r.rdata = e_rdata;
        r.cause = e_cause;
        q_rsp64.push_back(r);
        if (exp_mem) begin
            m.we = we; m.addr = e_addr; m.be = e_be; m.wdata = e_wdata;
            q_mem64.push_back(m);
        end
        @(posedge clk); #1;
        b64.req_valid = 1'b1; b64.req_we = we; b64.req_funct = funct;
        b64.req_addr = addr;  b64.req_wdata = wdata;
        @(posedge clk); #1;
        b64.req_valid = 1'b0;
        check("mem64_valid_n1", b64.mem_valid, exp_mem);
        if (exp_mem) begin
            @(posedge clk); #1;
            b64.mem_ready = 1'b1; b64.mem_rdata = mrdata;
            @(posedge clk); #1;
            b64.mem_ready = 1'b0; b64.mem_rdata = '0;
        end
        check("rsp64_valid_slot", b64.rsp_valid, 1);
        @(posedge clk); #1;
        check("req64_ready_after", b64.req_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : p_main
        rsp_t r;
        int   n;
        b32.req_valid = 0; b32.req_we = 0; b32.req_funct = 0; b32.req_addr = 0;
        b32.req_wdata = 0; b32.mem_ready = 0; b32.mem_rdata = 0; b32.mem_err = 0;
        b64.req_valid = 0; b64.req_we = 0; b64.req_funct = 0; b64.req_addr = 0;
        b64.req_wdata = 0; b64.mem_ready = 0; b64.mem_rdata = 0; b64.mem_err = 0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  b32.req_ready, 1);
        check("rst_mem_valid",  b32.mem_valid, 0);
        check("rst_mem_fields", {b32.mem_we, b32.mem_addr, b32.mem_wdata, b32.mem_be}, 0);
        check("rst_rsp_fields", {b32.rsp_valid, b32.rsp_rdata, b32.rsp_err, b32.rsp_cause}, 0);
        check("rst64_req_ready", b64.req_ready, 1);
        reset = 1'b0;
        mon_en = 1'b1;

        //     we  funct   addr          wdata         mrdata        err dly mem e_addr        be       e_wdata       e_rdata       cause
        txn32(0, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 0, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 3'd0); // LB
        txn32(0, 3'b100, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 0, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 3'd0); // LBU
        txn32(1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'hDEAD_BEEF, 0, 1, 1, 32'h0000_0100, 4'b1100, 32'h1234_0000, 32'h0,        3'd0); // SH
        txn32(1, 3'b000, 32'h0000_0101, 32'hFFFF_FFAB, 32'h0,        0, 0, 1, 32'h0000_0100, 4'b0010, 32'h0000_AB00, 32'h0,        3'd0); // SB
        txn32(0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 2, 1, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001, 3'd0); // LH
        txn32(0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_8765, 0, 0, 1, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000_8765, 3'd0); // LHU
        txn32(0, 3'b010, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 0, 3, 1, 32'h0000_0104, 4'b1111, 32'h0,        32'hCAFE_F00D, 3'd0); // LW, ready at limit
        txn32(0, 3'b010, 32'h0000_0010, 32'h0,        32'h1234_5678, 1, 1, 1, 32'h0000_0010, 4'b1111, 32'h0,        32'h0,        3'd2); // bus error
        txn32(0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd1); // LW misaligned
        txn32(0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd1); // LH misaligned
        txn32(0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd4); // LD on 32
        txn32(0, 3'b011, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd4); // illegal beats misalign
        txn32(0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd4); // LWU on 32
        txn32(1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'd4); // store funct[2]=1

        // Timeout: mem_ready never comes.
        r.rdata = 64'h0; r.cause = 3'd3;
        q_rsp32.push_back(r);
        @(posedge clk); #1;
        b32.req_valid = 1; b32.req_we = 0; b32.req_funct = 3'b010; b32.req_addr = 32'h200;
        @(posedge clk); #1;
        b32.req_valid = 0;
        n = 0;
        while (b32.mem_valid && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("timeout_mem_valid_cycles", n, 4);
        check("timeout_rsp_valid", b32.rsp_valid, 1);
        @(posedge clk); #1;
        check("timeout_req_ready", b32.req_ready, 1);

        // Reset in the middle of a bus transfer: no response may follow.
        @(posedge clk); #1;
        b32.req_valid = 1; b32.req_we = 0; b32.req_funct = 3'b010; b32.req_addr = 32'h300;
        @(posedge clk); #1;
        b32.req_valid = 0;
        check("rstbus_in_bus", b32.mem_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstbus_mem_valid", b32.mem_valid, 0);
        check("rstbus_req_ready", b32.req_ready, 1);
        check("rstbus_mem_fields", {b32.mem_addr, b32.mem_be}, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("rstbus_no_rsp", b32.rsp_valid, 0);
        end

        // mem_ready/mem_err outside BUS are ignored.
        b32.mem_ready = 1; b32.mem_err = 1; b32.mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_ready_ignored", {b32.rsp_valid, b32.mem_valid, b32.req_ready}, 3'b001);
        end
        b32.mem_ready = 0; b32.mem_err = 0; b32.mem_rdata = 0;

        //     we  funct   addr                   wdata                  mrdata                 mem e_addr                 be     e_wdata                e_rdata                cause
        txn64(0, 3'b011, 64'h8,                 64'h0,                 64'h8000_0000_0000_0001, 1, 64'h8,                 8'hFF, 64'h0,                 64'h8000_0000_0000_0001, 3'd0); // LD
        txn64(0, 3'b010, 64'hC,                 64'h0,                 64'h8765_4321_0000_0000, 1, 64'h8,                 8'hF0, 64'h0,                 64'hFFFF_FFFF_8765_4321, 3'd0); // LW
        txn64(0, 3'b110, 64'hC,                 64'h0,                 64'h8765_4321_0000_0000, 1, 64'h8,                 8'hF0, 64'h0,                 64'h0000_0000_8765_4321, 3'd0); // LWU
        txn64(1, 3'b010, 64'h4,                 64'h1111_2222_3333_4444, 64'h0,                 1, 64'h0,                 8'hF0, 64'h3333_4444_0000_0000, 64'h0,                 3'd0); // SW
        txn64(0, 3'b111, 64'h8,                 64'h0,                 64'h0,                 0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 3'd4); // funct 111
        txn64(0, 3'b011, 64'h4,                 64'h0,                 64'h0,                 0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 3'd1); // LD misaligned

        repeat (2) @(posedge clk);
        #1;
        check("rsp32_drained", q_rsp32.size(), 0);
        check("mem32_drained", q_mem32.size(), 0);
        check("rsp64_drained", q_rsp64.size(), 0);
        check("mem64_drained", q_mem64.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, bus wait limit in cycles; 0 disables the timeout.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Core request ports SHALL be:
- req_valid, in, 1
- req_ready, out, 1
- req_we, in, 1: 1 = store
- req_funct, in, 3: RISC-V funct3
- req_addr, in, XLEN
- req_wdata, in, XLEN
REQ-006 Core response ports SHALL be:
- rsp_valid, out, 1
- rsp_rdata, out, XLEN
- rsp_err, out, 1
- rsp_cause, out, 3
REQ-007 Memory ports SHALL be:
- mem_valid, out, 1
- mem_ready, in, 1
- mem_we, out, 1
- mem_addr, out, XLEN
- mem_wdata, out, XLEN
- mem_be, out, XLEN/8
- mem_rdata, in, XLEN
- mem_err, in, 1

Function
REQ-008 The block SHALL implement the FSM IDLE -> BUS -> RESP -> IDLE, plus IDLE -> RESP for rejected requests.
REQ-009 req_ready SHALL be 1 exactly when state is IDLE; a request is accepted when req_valid & req_ready.
REQ-010 Size SHALL be taken from funct[1:0]: 00 byte, 01 half, 10 word, 11 double. For loads, funct[2]=1 SHALL zero-extend and funct[2]=0 SHALL sign-extend.
REQ-011 These encodings SHALL be illegal and SHALL produce cause 4:
- XLEN=32: double (funct[1:0]=11) or funct 110.
- Any XLEN: funct 111.
- Stores: funct[2]=1.
REQ-012 An address whose low bits are not a multiple of the access size SHALL produce cause 1 (misaligned). Cause 4 SHALL take precedence over cause 1.
REQ-013 A rejected request SHALL never assert mem_valid; rsp_valid SHALL pulse in the cycle after acceptance.
REQ-014 For a legal request accepted in cycle N, mem_valid SHALL be registered high from cycle N+1 and held with stable mem_* outputs until the cycle in which mem_ready=1.
REQ-015 mem_addr SHALL be req_addr with the low log2(XLEN/8) bits cleared.
REQ-016 mem_be SHALL be the size mask shifted left by the byte offset.
REQ-017 mem_wdata SHALL be req_wdata shifted left by 8*offset; unused lanes SHALL be 0.
REQ-018 rsp_valid SHALL pulse for exactly one cycle, the cycle after mem_ready; the response has no backpressure.
REQ-019 On a load, rsp_rdata SHALL be mem_rdata shifted right by 8*offset, then sign- or zero-extended to XLEN.
REQ-020 On a store, rsp_rdata SHALL be 0.
REQ-021 If mem_err=1 in the mem_ready cycle, the response SHALL carry rsp_err=1, cause 2, and rsp_rdata=0.
REQ-022 Timeout: a counter SHALL clear on entering BUS and increment each BUS cycle without mem_ready.
REQ-023 When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_ready, mem_valid SHALL drop in the next cycle and the response SHALL carry cause 3 (timeout).
REQ-024 If mem_ready arrives in the same cycle the limit is reached, the normal completion SHALL win.
REQ-025 rsp_err SHALL equal (rsp_cause != 0). Cause 0 = OK.
REQ-026 While rsp_valid=0, rsp_rdata, rsp_err and rsp_cause SHALL be 0.
REQ-027 mem_ready or mem_err asserted while not in BUS SHALL be ignored.

Reset
REQ-028 Reset SHALL override all other events, including a transaction in flight.
REQ-029 After reset the state SHALL be IDLE and req_ready=1.
REQ-030 After reset these outputs SHALL be 0: mem_valid, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata, rsp_err, rsp_cause. The timeout counter SHALL also be 0.
REQ-031 No response SHALL be produced for a transaction cut off by reset.

Structure
REQ-032 Package riscv_lsu_pkg SHALL hold:
- the FSM state enum;
- the cause enum (OK=0, MISALIGN=1, BUSERR=2, TIMEOUT=3, ILLEGAL=4);
- funct3 size localparams.
REQ-033 Sub-module lsu_align (combinational) SHALL perform byte-enable generation, write-lane shift, read-lane shift and extension.
REQ-034 All other logic SHALL be registered inside riscv_lsu.

Verification
REQ-035 XLEN=32, LB at 0x103, mem_rdata=0x80000000 -> mem_addr=0x100, mem_be=1000, rsp_rdata=0xFFFFFF80. The same access as LBU -> rsp_rdata=0x00000080.
REQ-036 SH at 0x102, wdata=0x00001234 -> mem_addr=0x100, mem_be=1100, mem_wdata=0x12340000, mem_we=1, rsp_err=0.
REQ-037 LW at 0x101 -> mem_valid never asserted, rsp_valid in cycle N+1 with rsp_cause=1. funct=011 at XLEN=32 -> rsp_cause=4.
REQ-038 TIMEOUT=4, mem_ready held at 0 -> mem_valid high for 4 cycles, then rsp_cause=3 and req_ready=1.
REQ-039 mem_ready=1 with mem_err=1 -> rsp_err=1, rsp_cause=2, rsp_rdata=0.
REQ-040 reset pulsed during BUS -> next cycle mem_valid=0, no rsp_valid pulse, req_ready=1. XLEN=64 LD at 0x8 -> mem_be=0xFF.
